// File: rtl/hs_pkg.sv
// Shared types and limits for the req/ack bundled-data CDC receiver.
package hs_pkg;

    // Receiver handshake state: IDLE waits for req, WAIT_LOW holds ack until req drops.
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } hs_state_e;

    // Legal depth range for the req synchronizer chain.
    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 4;

    // True when a requested synchronizer depth is within the supported range.
    function automatic logic sync_depth_ok(input int depth);
        return (depth >= SYNC_MIN) && (depth <= SYNC_MAX);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// N-flop single-bit synchronizer for an asynchronous level input.
// Each stage is a plain DFF with asynchronous active-low clear; the chain
// carries the ASYNC_REG attribute so CDC tools recognise it as a synchronizer.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic ck_i,
    input  logic rs_ni,
    input  logic d_i,
    output logic q_o
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the metastability-settling chain.
    always_ff @(posedge ck_i or negedge rs_ni) begin
        if (!rs_ni) begin
            sync_q <= {STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/hs_rx_sync_chk.sv
// Protocol checker for hs_rx_sync: observes the handshake and buffer signals.
module hs_rx_sync_chk (
    input logic ck_i,
    input logic rs_ni,
    input logic ack_i,
    input logic dout_valid_i,
    input logic dout_ready_i,
    input logic req_s_i,
    input logic load_i
);

    // ack must not rise while the buffer is full and nothing is being consumed.
    property p_no_ack_when_blocked;
        @(posedge ck_i) disable iff (!rs_ni)
            (!ack_i && dout_valid_i && !dout_ready_i) |=> !ack_i;
    endproperty
    a_no_ack_when_blocked: assert property (p_no_ack_when_blocked)
        else $error("hs_rx_sync_chk: ack rose while buffer blocked");

    // The bundled data may only be captured while the synchronized req is high.
    property p_load_needs_req;
        @(posedge ck_i) disable iff (!rs_ni)
            load_i |-> req_s_i;
    endproperty
    a_load_needs_req: assert property (p_load_needs_req)
        else $error("hs_rx_sync_chk: din captured while req_s low");

endmodule

// File: rtl/hs_rx_sync.sv
// Responder end of a 4-phase req/ack bundled-data link.
// req is synchronized into CK, the bundled word is captured into a one-entry
// buffer offered to a local consumer with valid/ready, and ack is returned.
// All outputs come straight from flops.
module hs_rx_sync
    import hs_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic              CK,
    input  logic              RS,
    input  logic              req,
    input  logic [DATA_W-1:0] din,
    output logic              ack,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [CNT_W-1:0]  xfer_count
);

    // Reject an unsupported synchronizer depth at elaboration time.
    if (!sync_depth_ok(SYNC_STAGES)) begin : g_bad_sync_depth
        $error("hs_rx_sync: SYNC_STAGES must lie in SYNC_MIN..SYNC_MAX");
    end

    hs_state_e         state_q, state_d;
    logic              ack_q, ack_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic req_s_s;
    logic pop_s;
    logic load_s;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .ck_i  (CK),
        .rs_ni (RS),
        .d_i   (req),
        .q_o   (req_s_s)
    );

    // Next-state logic: handshake FSM, buffer load/pop and transfer counting.
    always_comb begin
        state_d      = state_q;
        ack_d        = ack_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        cnt_d        = cnt_q;
        load_s       = 1'b0;
        pop_s        = dout_valid_q & dout_ready;

        case (state_q)
            IDLE: begin
                // A pop in this cycle frees the buffer, so load and pop may coincide.
                if (req_s_s && (!dout_valid_q || pop_s)) begin
                    load_s  = 1'b1;
                    ack_d   = 1'b1;
                    state_d = WAIT_LOW;
                end else begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            WAIT_LOW: begin
                // din is not looked at here; the word was taken on entry.
                if (!req_s_s) begin
                    ack_d   = 1'b0;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end else begin
                    ack_d   = 1'b1;
                    state_d = WAIT_LOW;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        // A load wins over a pop: the new word replaces the consumed one.
        if (load_s) begin
            dout_d       = din;
            dout_valid_d = 1'b1;
        end else if (pop_s) begin
            dout_valid_d = 1'b0;
        end else begin
            dout_valid_d = dout_valid_q;
        end
    end

    // State, buffer, acknowledge and counter registers; reset discards any held word.
    always_ff @(posedge CK or negedge RS) begin
        if (!RS) begin
            state_q      <= IDLE;
            ack_q        <= 1'b0;
            dout_q       <= {DATA_W{1'b0}};
            dout_valid_q <= 1'b0;
            cnt_q        <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign ack        = ack_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign xfer_count = cnt_q;

endmodule
